// File: rtl/systolic_ctrl.sv
// systolic_ctrl: clears, feeds (diagonally skewed), drains and reads out a DIM x DIM systolic MAC array.
// Define SA_CTRL_ACCUM_EN to honour `accum` (start with accum skips CLEAR and adds onto the existing C).
module systolic_ctrl #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        accum,
    output logic                        busy,
    output logic                        done,
    output logic                        mem_rd_en,
    output logic [$clog2(DIM)-1:0]      mem_rd_addr,
    input  logic [DIM-1:0][BITS_AB-1:0] A_mem,
    input  logic [DIM-1:0][BITS_AB-1:0] B_mem,
    output logic [DIM-1:0][BITS_AB-1:0] sa_A,
    output logic [DIM-1:0][BITS_AB-1:0] sa_B,
    output logic                        sa_en,
    output logic                        sa_WrEn,
    output logic [$clog2(DIM)-1:0]      sa_Crow,
    output logic [DIM-1:0][BITS_C-1:0]  sa_Cin,
    output logic                        c_valid,
    input  logic                        c_ready,
    output logic [$clog2(DIM)-1:0]      c_row
);

    localparam int RW = $clog2(DIM);
    localparam int CW = $clog2(3 * DIM);
    localparam bit DIM_POW2 = (DIM & (DIM - 1)) == 0;
    localparam logic [CW-1:0] LAST_K     = CW'(DIM - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(2 * DIM - 2);
    localparam logic [RW-1:0] LAST_ROW   = RW'(DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_READ
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] phase;
    logic [RW-1:0] row, row_inc;
    logic          done_set;
    logic          rd_valid;
    logic          start_accum;

`ifdef SA_CTRL_ACCUM_EN
    assign start_accum = accum;
`else
    logic unused_accum;
    assign unused_accum = accum;
    assign start_accum  = 1'b0;
`endif

    // Row index: free-running wrap is exact only for power-of-two DIM.
    always_comb begin
        row_inc = row + RW'(1);
        if (!DIM_POW2 && row == LAST_ROW) row_inc = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            phase    <= '0;
            row      <= '0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state    <= state_next;
            phase    <= (state_next != state) ? '0 : phase + CW'(1);
            done     <= done_set;
            rd_valid <= mem_rd_en;
            if (state != S_READ) row <= '0;
            else if (c_ready)    row <= row_inc;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next  = state;
        busy        = 1'b1;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        sa_en       = 1'b0;
        sa_WrEn     = 1'b0;
        sa_Crow     = '0;
        c_valid     = 1'b0;
        done_set    = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                // The cycle carrying `done` still looks IDLE, but a start there is dropped.
                if (start && !done) state_next = start_accum ? S_FEED : S_CLEAR;
            end
            S_CLEAR: begin
                sa_WrEn = 1'b1;
                sa_Crow = phase[RW-1:0];
                if (phase == LAST_K) state_next = S_FEED;
            end
            S_FEED: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = phase[RW-1:0];
                sa_en       = 1'b1;
                if (phase == LAST_K) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                sa_en = 1'b1;
                if (phase == LAST_DRAIN) state_next = S_READ;
            end
            S_READ: begin
                c_valid = 1'b1;
                sa_Crow = row;
                if (c_ready && row == LAST_ROW) begin
                    state_next = S_IDLE;
                    done_set   = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign c_row  = sa_Crow;
    assign sa_Cin = '0;

    // Memory data is only trusted the cycle after a read strobe; otherwise lanes carry zero.
    logic [DIM-1:0][BITS_AB-1:0] a_cap, b_cap;
    assign a_cap = rd_valid ? A_mem : '0;
    assign b_cap = rd_valid ? B_mem : '0;

    assign sa_A[0] = a_cap[0];
    assign sa_B[0] = b_cap[0];

    for (genvar i = 1; i < DIM; i++) begin : g_skew
        logic [BITS_AB-1:0] a_dl [i];
        logic [BITS_AB-1:0] b_dl [i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < i; s++) begin
                    a_dl[s] <= '0;
                    b_dl[s] <= '0;
                end
            end else begin
                a_dl[0] <= a_cap[i];
                b_dl[0] <= b_cap[i];
                for (int s = 1; s < i; s++) begin
                    a_dl[s] <= a_dl[s-1];
                    b_dl[s] <= b_dl[s-1];
                end
            end
        end

        assign sa_A[i] = a_dl[i-1];
        assign sa_B[i] = b_dl[i-1];
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: operand memory and a behavioural systolic array around the DUT,
// results compared against a plain matrix product.
module tb_systolic_ctrl;

    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int DIM     = 8;
    localparam int RW      = $clog2(DIM);
    localparam int CTRL_W  = 6 + 3 * RW;

    logic                        clk, rst_n, start, accum, c_ready;
    logic                        busy, done, mem_rd_en, sa_en, sa_WrEn, c_valid;
    logic [RW-1:0]               mem_rd_addr, sa_Crow, c_row;
    logic [DIM-1:0][BITS_AB-1:0] A_mem, B_mem, sa_A, sa_B;
    logic [DIM-1:0][BITS_C-1:0]  sa_Cin;

    int checks = 0;
    int errors = 0;

    logic signed [BITS_AB-1:0] mat_a [DIM][DIM];  // A[i][k]
    logic signed [BITS_AB-1:0] mat_b [DIM][DIM];  // B[k][j]
    int                        exp_c [DIM][DIM];

    logic signed [BITS_AB-1:0] pa  [DIM][DIM];
    logic signed [BITS_AB-1:0] pb  [DIM][DIM];
    logic signed [BITS_C-1:0]  acc [DIM][DIM];

    systolic_ctrl #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .accum(accum),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .A_mem(A_mem), .B_mem(B_mem), .sa_A(sa_A), .sa_B(sa_B),
        .sa_en(sa_en), .sa_WrEn(sa_WrEn), .sa_Crow(sa_Crow), .sa_Cin(sa_Cin),
        .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Operand memory: one-cycle read latency, junk on cycles without a read.
    always @(posedge clk) begin
        for (int x = 0; x < DIM; x++) begin
            A_mem[x] <= mem_rd_en ? mat_a[x][mem_rd_addr] : BITS_AB'($urandom);
            B_mem[x] <= mem_rd_en ? mat_b[mem_rd_addr][x] : BITS_AB'($urandom);
        end
    end

    // Output-stationary array: A flows right along rows, B flows down columns.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    pa[i][j] <= '0;
                    pb[i][j] <= '0;
                end
        end else begin
            if (sa_WrEn)
                for (int j = 0; j < DIM; j++) acc[sa_Crow][j] <= sa_Cin[j];
            if (sa_en)
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++) begin
                        logic signed [BITS_AB-1:0] ain, bin;
                        if (j == 0) ain = sa_A[i]; else ain = pa[i][j-1];
                        if (i == 0) bin = sa_B[j]; else bin = pb[i-1][j];
                        pa[i][j]  <= ain;
                        pb[i][j]  <= bin;
                        acc[i][j] <= acc[i][j] + ain * bin;
                    end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CTRL_W-1:0] ctrl_obs();
        return {busy, done, mem_rd_en, mem_rd_addr, sa_en, sa_WrEn, sa_Crow, c_valid, c_row};
    endfunction

    function automatic logic [CTRL_W-1:0] ctrl_exp(bit b, bit d, bit rd, int addr, bit en,
                                                  bit wr, int crow, bit cv);
        return {b, d, rd, RW'(addr), en, wr, RW'(crow), cv, RW'(crow)};
    endfunction

    // A[i][k] is due on lane i at cycle t0+k+1+i; B[k][j] on lane j at t0+k+1+j.
    function automatic logic [DIM*BITS_AB-1:0] skew_a(int n, int t0);
        logic [DIM*BITS_AB-1:0] v = '0;
        for (int i = 0; i < DIM; i++) begin
            int d = n - t0 - 1 - i;
            if (d >= 0 && d < DIM) v[i*BITS_AB +: BITS_AB] = mat_a[i][d];
        end
        return v;
    endfunction

    function automatic logic [DIM*BITS_AB-1:0] skew_b(int n, int t0);
        logic [DIM*BITS_AB-1:0] v = '0;
        for (int j = 0; j < DIM; j++) begin
            int d = n - t0 - 1 - j;
            if (d >= 0 && d < DIM) v[j*BITS_AB +: BITS_AB] = mat_b[d][j];
        end
        return v;
    endfunction

    function automatic logic [DIM*BITS_C-1:0] exp_row(int r);
        logic [DIM*BITS_C-1:0] v;
        for (int j = 0; j < DIM; j++) v[j*BITS_C +: BITS_C] = BITS_C'(exp_c[r][j]);
        return v;
    endfunction

    function automatic logic [DIM*BITS_C-1:0] cout_row();
        logic [DIM*BITS_C-1:0] v;
        for (int j = 0; j < DIM; j++) v[j*BITS_C +: BITS_C] = acc[sa_Crow][j];
        return v;
    endfunction

    // ready_mode: 0 always ready, 1 repeating 1-0-0-1, 2 random with bounded stalls.
    task automatic run_matmul(input bit use_accum, input int ready_mode, input bit poke,
                              input bit abort, input bit start_on_done);
        bit eff;
        int cl, t0, rd0, r, stall, n;
`ifdef SA_CTRL_ACCUM_EN
        eff = use_accum;
`else
        eff = 1'b0;
`endif
        if (!eff)
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) exp_c[i][j] = 0;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                for (int k = 0; k < DIM; k++)
                    exp_c[i][j] += int'(mat_a[i][k]) * int'(mat_b[k][j]);

        cl  = eff ? 0 : DIM;
        t0  = cl + 1;
        rd0 = t0 + 3 * DIM - 1;

        @(negedge clk);
        check("idle_before_start", 256'(ctrl_obs()), 256'(ctrl_exp(0, 0, 0, 0, 0, 0, 0, 0)));
        start = 1'b1;
        accum = use_accum;

        for (n = 1; n < rd0; n++) begin
            bit clr, feed;
            @(negedge clk);
            start   = (poke && n == t0 + 1);
            accum   = 1'b0;
            c_ready = 1'($urandom_range(0, 1));
            if (abort && n == t0 + DIM + 2) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_ctrl", 256'(ctrl_obs()), '0);
                check("async_rst_lanes", 256'({sa_A, sa_B}), '0);
                check("async_rst_cin", 256'(sa_Cin), '0);
                start = 1'b0;
                @(negedge clk);
                rst_n   = 1'b1;
                c_ready = 1'b0;
                for (int w = 0; w < 3; w++) begin
                    @(negedge clk);
                    check($sformatf("post_rst_idle w=%0d", w), 256'(ctrl_obs()),
                          256'(ctrl_exp(0, 0, 0, 0, 0, 0, 0, 0)));
                end
                return;
            end
            clr  = (n <= cl);
            feed = (n >= t0 && n < t0 + DIM);
            check($sformatf("ctrl n=%0d", n), 256'(ctrl_obs()),
                  256'(ctrl_exp(1, 0, feed, feed ? n - t0 : 0, n >= t0, clr, clr ? n - 1 : 0, 0)));
            check($sformatf("sa_A n=%0d", n), 256'(sa_A), 256'(skew_a(n, t0)));
            check($sformatf("sa_B n=%0d", n), 256'(sa_B), 256'(skew_b(n, t0)));
        end

        r     = 0;
        stall = 0;
        while (r < DIM) begin
            @(negedge clk);
            start = (poke && n == rd0);
            check($sformatf("read_ctrl n=%0d", n), 256'(ctrl_obs()),
                  256'(ctrl_exp(1, 0, 0, 0, 0, 0, r, 1)));
            check($sformatf("cout row=%0d n=%0d", r, n), 256'(cout_row()), 256'(exp_row(r)));
            case (ready_mode)
                0:       c_ready = 1'b1;
                1:       c_ready = ((n - rd0) % 4 == 0) || ((n - rd0) % 4 == 3);
                default: c_ready = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            if (c_ready) begin
                r++;
                stall = 0;
            end else begin
                stall++;
            end
            n++;
        end

        @(negedge clk);
        c_ready = 1'b0;
        start   = start_on_done;
        check($sformatf("done_pulse n=%0d", n), 256'(ctrl_obs()),
              256'(ctrl_exp(0, 1, 0, 0, 0, 0, 0, 0)));
        if (!start_on_done) begin
            @(negedge clk);
            check("done_clears", 256'(ctrl_obs()), 256'(ctrl_exp(0, 0, 0, 0, 0, 0, 0, 0)));
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                mat_a[i][j] = BITS_AB'($urandom);
                mat_b[i][j] = BITS_AB'($urandom);
            end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        accum   = 1'b0;
        c_ready = 1'b0;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                mat_a[i][j] = (i == j) ? BITS_AB'(1) : '0;
                mat_b[i][j] = BITS_AB'(i * DIM + j);
            end

        @(negedge clk);
        check("reset_ctrl", 256'(ctrl_obs()), '0);
        check("reset_lanes", 256'({sa_A, sa_B}), '0);
        check("reset_cin", 256'(sa_Cin), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Identity A: result rows equal B.
        run_matmul(0, 0, 0, 0, 0);

        // All -1 operands, then an accumulate run chained straight after done,
        // with a start raised during the done cycle that must be dropped.
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                mat_a[i][j] = -1;
                mat_b[i][j] = -1;
            end
        run_matmul(0, 0, 0, 0, 1);
        run_matmul(1, 0, 0, 0, 0);

        // Random operands, 1-0-0-1 ready pattern, stray starts in FEED and READ.
        fill_random();
        run_matmul(0, 1, 1, 0, 0);

        // Reset during the third DRAIN cycle, then a clean run.
        fill_random();
        run_matmul(0, 0, 0, 1, 0);
        fill_random();
        run_matmul(0, 2, 0, 0, 0);

        // Accumulate onto the previous random result.
        fill_random();
        run_matmul(1, 2, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
